// File: rtl/booth_r4_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_r4_mult_seq
//
// Sequential radix-4 Booth multiplier for WIDTH x WIDTH operands. One Booth
// group is retired per clock through a single shared adder. The operation is
// started with a start/busy/done handshake. The product is 2*WIDTH bits wide.
//
// Latency: the edge that accepts i_start is E0. o_result and o_done update at
// edge E0+GROUPS, where GROUPS = WIDTH/2+1. o_busy is high from E0 up to, but
// not including, E0+GROUPS. o_done is high for exactly one cycle.
//
// Optional build macro BOOTH_UNSIGNED_MODE_EN:
//   When it is defined, the input i_tc is added. It is captured together with
//   the operands. i_tc=1 selects signed mode. i_tc=0 selects unsigned mode.
//   When it is undefined, there is no i_tc port and the block is always signed.
//
// Parameters:
//   WIDTH      operand width in bits. It must be even and >= 4.
//
// Ports:
//   i_clk      clock; all state updates happen on the rising edge
//   i_rst      synchronous reset, active high; it aborts any operation
//   i_start    request to begin a multiply; sampled only in IDLE
//   i_a_in     multiplicand [WIDTH-1:0], captured on the accepting edge
//   i_b_in     multiplier   [WIDTH-1:0], captured on the accepting edge
//   i_tc       (BOOTH_UNSIGNED_MODE_EN only) 1 = signed, 0 = unsigned
//   o_result   registered product [2*WIDTH-1:0]; holds until the next completion
//   o_busy     high while a multiply is in progress
//   o_done     one-cycle pulse when o_result is updated
// -----------------------------------------------------------------------------
module booth_r4_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a_in,
    input  logic [WIDTH-1:0]   i_b_in,
`ifdef BOOTH_UNSIGNED_MODE_EN
    input  logic               i_tc,
`endif
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_busy,
    output logic               o_done
);

    localparam int GROUPS = WIDTH / 2 + 1;
    localparam int ACC_W  = 2 * WIDTH + 2;
    // The extended multiplier has WIDTH+2 bits plus the implicit 0 below the LSB.
    localparam int MUL_W  = WIDTH + 3;
    localparam int CNT_W  = $clog2(GROUPS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_mcand;    // extended multiplicand, pre-shifted by 2*count
    logic [MUL_W-1:0]    r_mplier;   // extended multiplier, current group in [2:0]
    logic [CNT_W-1:0]    r_count;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_mcand_nxt;
    logic [MUL_W-1:0]    w_mplier_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [2*WIDTH-1:0]  w_result_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                w_signed;
    logic [ACC_W-1:0]    w_a_ext;
    logic [MUL_W-1:0]    w_b_ext;
    logic [ACC_W-1:0]    w_mag;
    logic                w_neg;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_sum;

`ifdef BOOTH_UNSIGNED_MODE_EN
    assign w_signed = i_tc;
`else
    assign w_signed = 1'b1;
`endif

    // Operand extension: sign-extend or zero-extend. The multiplicand is
    // extended straight to the accumulator width, so shifting it never loses
    // sign bits. In unsigned mode the zero top bits of the multiplier make the
    // extra group supply the final correction term.
    assign w_a_ext = {{(ACC_W - WIDTH){w_signed & i_a_in[WIDTH-1]}}, i_a_in};
    assign w_b_ext = {{2{w_signed & i_b_in[WIDTH-1]}}, i_b_in, 1'b0};

    // Booth radix-4 recoding of the current group into a magnitude and a negate flag.
    always_comb begin
        w_mag = {ACC_W{1'b0}};
        w_neg = 1'b0;
        case (r_mplier[2:0])
            3'b000, 3'b111: begin
                w_mag = {ACC_W{1'b0}};
                w_neg = 1'b0;
            end
            3'b001, 3'b010: begin
                w_mag = r_mcand;
                w_neg = 1'b0;
            end
            3'b011: begin
                w_mag = r_mcand << 1;
                w_neg = 1'b0;
            end
            3'b100: begin
                w_mag = r_mcand << 1;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = r_mcand;
                w_neg = 1'b1;
            end
            default: begin
                w_mag = {ACC_W{1'b0}};
                w_neg = 1'b0;
            end
        endcase
    end

    // Single shared adder. A negative partial product is added as its
    // inversion plus a carry-in of 1.
    assign w_addend = w_neg ? ~w_mag : w_mag;
    assign w_sum    = r_acc + w_addend + {{(ACC_W-1){1'b0}}, w_neg};

    // Next-state and next-output logic of the IDLE/CALC controller.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_count_nxt  = r_count;
        w_result_nxt = r_result;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_acc_nxt    = {ACC_W{1'b0}};
                    w_mcand_nxt  = w_a_ext;
                    w_mplier_nxt = w_b_ext;
                    w_count_nxt  = {CNT_W{1'b0}};
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_CALC;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_CALC: begin
                // The operands are shifted, not indexed, so each group is
                // always found in the same place.
                w_acc_nxt    = w_sum;
                w_mcand_nxt  = r_mcand << 2;
                w_mplier_nxt = r_mplier >> 2;
                if (r_count == CNT_W'(GROUPS - 1)) begin
                    w_result_nxt = w_sum[2*WIDTH-1:0];
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_count_nxt  = {CNT_W{1'b0}};
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_count_nxt  = r_count + CNT_W'(1);
                    w_state_nxt  = ST_CALC;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. The synchronous reset has priority over everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= {ACC_W{1'b0}};
            r_mcand  <= {ACC_W{1'b0}};
            r_mplier <= {MUL_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_result <= {(2*WIDTH){1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_count  <= w_count_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_result = r_result;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Self-checking bench for booth_r4_mult_seq.
// The main instance uses WIDTH=8. There are also small WIDTH=4 and WIDTH=16
// instances.
// Expected products are pushed to a scoreboard when an operation is accepted.
// A monitor pops an entry on each done pulse and checks both the value and
// the latency.
module tb_booth_r4_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = 8'h00;
    logic [7:0]  b8 = 8'h00;
    logic        tc8 = 1'b1;
    logic [15:0] res8;
    logic        busy8;
    logic        done8;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = 4'h0;
    logic [3:0]  b4 = 4'h0;
    logic [7:0]  res4;
    logic        busy4;
    logic        done4;

    logic        start16 = 1'b0;
    logic [15:0] a16 = 16'h0000;
    logic [15:0] b16 = 16'h0000;
    logic [31:0] res16;
    logic        busy16;
    logic        done16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] last_result = 16'h0000;

    typedef struct {
        logic [15:0] exp;
        int          due;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    booth_r4_mult_seq #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a_in(a8), .i_b_in(b8),
`ifdef BOOTH_UNSIGNED_MODE_EN
        .i_tc(tc8),
`endif
        .o_result(res8), .o_busy(busy8), .o_done(done8)
    );

    booth_r4_mult_seq #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a_in(a4), .i_b_in(b4),
`ifdef BOOTH_UNSIGNED_MODE_EN
        .i_tc(1'b1),
`endif
        .o_result(res4), .o_busy(busy4), .o_done(done4)
    );

    booth_r4_mult_seq #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start16), .i_a_in(a16), .i_b_in(b16),
`ifdef BOOTH_UNSIGNED_MODE_EN
        .i_tc(1'b1),
`endif
        .o_result(res16), .o_busy(busy16), .o_done(done16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (done8) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("result8", {16'h0000, res8}, {16'h0000, e.exp});
                chk("latency8", cyc, e.due);
                last_result = e.exp;
            end
        end
    end

    // Wait, with a bound, until the scoreboard has drained.
    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    // Run one complete operation on the WIDTH=8 instance. This also checks
    // that busy is high and the previous result is held while it runs.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic tc,
                          input logic [15:0] exp);
        sb_t e;
        @(negedge clk);
        a8 = a; b8 = b; tc8 = tc; start8 = 1'b1;
        @(posedge clk); #1;
        e.exp = exp; e.due = cyc + 5;
        sb_q.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        tc8 = 1'($urandom);
        for (int k = 0; k < 5; k++) begin
            chk("busy_during_op", {31'd0, busy8}, 32'd1);
            chk("result_held", {16'h0000, res8}, {16'h0000, last_result});
            @(negedge clk);
        end
        chk("busy_after_op", {31'd0, busy8}, 32'd0);
        wait_drain();
    endtask

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{a: 8'h7F, b: 8'h80, exp: 16'hC080};
        vecs[1]  = '{a: 8'h80, b: 8'h80, exp: 16'h4000};
        vecs[2]  = '{a: 8'h00, b: 8'hFF, exp: 16'h0000};
        vecs[3]  = '{a: 8'h03, b: 8'hFD, exp: 16'hFFF7};
        vecs[4]  = '{a: 8'h05, b: 8'h06, exp: 16'h001E};
        vecs[5]  = '{a: 8'h7F, b: 8'h7F, exp: 16'h3F01};
        vecs[6]  = '{a: 8'hFF, b: 8'hFF, exp: 16'h0001};
        vecs[7]  = '{a: 8'h01, b: 8'h80, exp: 16'hFF80};
        vecs[8]  = '{a: 8'h12, b: 8'h34, exp: 16'h03A8};
        vecs[9]  = '{a: 8'h80, b: 8'h01, exp: 16'hFF80};
        vecs[10] = '{a: 8'h80, b: 8'hFF, exp: 16'h0080};
        vecs[11] = '{a: 8'hFF, b: 8'h00, exp: 16'h0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", {16'h0000, res8}, 32'd0);
        chk("reset_busy", {31'd0, busy8}, 32'd0);
        chk("reset_done", {31'd0, done8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
        end

        // Random signed vectors checked against a behavioural product
        for (int i = 0; i < 6; i++) begin
            logic signed [7:0]  ra;
            logic signed [7:0]  rb;
            logic signed [15:0] rp;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = ra * rb;
            run_op(ra, rb, 1'b1, rp);
        end

        // Start held high through busy (ignored), then accepted in the done cycle.
        begin
            sb_t e;
            @(negedge clk);
            a8 = 8'h7F; b8 = 8'h80; tc8 = 1'b1; start8 = 1'b1;
            @(posedge clk); #1;
            e.exp = 16'hC080; e.due = cyc + 5;
            sb_q.push_back(e);
            @(negedge clk);
            a8 = 8'h55; b8 = 8'h55;
            for (int k = 0; k < 5; k++) begin
                chk("b2b_busy", {31'd0, busy8}, 32'd1);
                @(negedge clk);
            end
            a8 = 8'h03; b8 = 8'hFD;
            @(posedge clk); #1;
            e.exp = 16'hFFF7; e.due = cyc + 5;
            sb_q.push_back(e);
            start8 = 1'b0;
            @(negedge clk);
            chk("b2b_second_busy", {31'd0, busy8}, 32'd1);
            wait_drain();
        end

        // Reset at the 3rd CALC edge aborts the operation without a done pulse.
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_result", {16'h0000, res8}, 32'd0);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_result = 16'h0000;
        repeat (8) @(negedge clk);
        run_op(8'h05, 8'h06, 1'b1, 16'h001E);

`ifdef BOOTH_UNSIGNED_MODE_EN
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_op(8'h80, 8'h02, 1'b0, 16'h0100);
`endif

        // WIDTH=4: 7 * -8 = -56 after 3 cycles
        begin
            int n = 0;
            @(negedge clk);
            a4 = 4'h7; b4 = 4'h8; start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            while (!done4 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("w4_latency", n, 32'd3);
            chk("w4_result", {24'h000000, res4}, 32'h000000C8);
        end

        // WIDTH=16: 0x8000 * 0x7FFF after 9 cycles
        begin
            int n = 0;
            @(negedge clk);
            a16 = 16'h8000; b16 = 16'h7FFF; start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            while (!done16 && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            chk("w16_latency", n, 32'd9);
            chk("w16_result", res16, 32'hC0008000);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/booth_r4_mult_seq.md
Name: booth_r4_mult_seq

Overview:
- Parametrised sequential radix-4 Booth multiplier. Successor to the fixed 4x4 multiplier: generalised to WIDTH x WIDTH operands.
- Handles two's-complement operands, and unsigned operands when the mode feature is compiled in.
- Retires one Booth group per clock, using a single shared adder and a start/busy/done handshake.
- Sits on the datapath between the operand registers and the result consumer, under control of the block's own FSM.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4. Product width is 2*WIDTH.
- GROUPS, WIDTH/2+1, derived localparam, not overridable: number of Booth groups processed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active high.
- start  input  1  request to begin a multiply; sampled only in IDLE.
- a_in  input  WIDTH  multiplicand; captured on the accepting edge.
- b_in  input  WIDTH  multiplier; captured on the accepting edge.
- result  output  2*WIDTH  product, registered; holds until the next completion.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, result=0, busy=0, done=0, accumulator and counter cleared.
  - Reset has priority over every other event, including an operation in progress. An aborted operation produces no done pulse.
- FSM states: IDLE and CALC.
  - IDLE, start=1: capture the operands, clear the accumulator, set count=0, busy<=1, go to CALC.
  - IDLE, start=0: stay in IDLE.
  - CALC: each edge processes group[count]. When count==GROUPS-1, write result, pulse done, set busy<=0 and return to IDLE. Otherwise count<=count+1.
- Operand extension (signed mode):
  - Multiplicand is sign-extended to WIDTH+2 bits.
  - Multiplier is sign-extended to WIDTH+2 bits, with an implicit 0 appended below the LSB.
- Booth groups: group i = bits {2i+1, 2i, 2i-1} of the extended multiplier.
- Recoding, per group value:
  - 000 and 111 -> 0
  - 001 and 010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101 and 110 -> -A
  - Negation is by inversion plus carry-in, all in two's complement.
- Accumulation:
  - The partial product is shifted left by 2i and sign-extended to the 2*WIDTH+2-bit accumulator.
  - result = accumulator[2*WIDTH-1:0].
  - The extra group (GROUPS = WIDTH/2+1) evaluates to 0 for signed operands. This keeps latency identical across modes.
- Latency:
  - Let E0 be the edge that accepts start.
  - result and done update at edge E0+GROUPS; done is high for exactly the following cycle.
  - busy is high from E0 up to, but not including, E0+GROUPS.
  - WIDTH=8 gives 5 cycles.
- start while busy: ignored; no queuing and no effect on the operation in flight.
- Back-to-back operation: start=1 in the done cycle (state is already IDLE) is accepted. The new operation completes GROUPS cycles later, giving a throughput of one result per GROUPS+1 cycles.
- Operand stability: a_in and b_in are don't-care after the accepting edge.
- Boundary cases:
  - Most-negative x most-negative (e.g. -128*-128) must give the exact positive product; no overflow is possible within 2*WIDTH bits.
  - Zero operands must still take the full latency.

Optional Feature:
- Macro: BOOTH_UNSIGNED_MODE_EN.
- Defined:
  - Adds input port tc (1 bit), captured together with the operands.
  - tc=1 selects signed mode.
  - tc=0 zero-extends both operands to WIDTH+2 bits and treats them as unsigned. The extra group then supplies the final +A or +2A correction.
  - Latency is unchanged.
- Not defined:
  - No tc port; the block is always signed.
  - Port list and behaviour are otherwise identical.

Test Plan:
- WIDTH=8. Reset, then a_in=0x7F, b_in=0x80, start pulse -> busy for 5 cycles, then done=1 for one cycle, result=0xC080 (-16256).
- WIDTH=8. a_in=0x80, b_in=0x80 -> result=0x4000. Then a_in=0, b_in=0xFF -> result=0x0000 after the full 5-cycle latency.
- WIDTH=8. Start held high through the done cycle with new operands 3 and -3 -> second operation accepted in the done cycle, result=0xFFF7. Starts asserted during busy are ignored.
- WIDTH=8. Start, then rst=1 at the 3rd CALC edge -> result=0, busy=0, no done pulse. A following start with 5*6 gives 0x001E.
- WIDTH=4. a_in=0x7, b_in=0x8 -> result=0xC8 (-56) after 3 cycles. WIDTH=16: 0x8000*0x7FFF -> 0xC0008000.
- BOOTH_UNSIGNED_MODE_EN, WIDTH=8:
  - tc=0, 0xFF*0xFF -> 0xFE01.
  - tc=1, same operands -> 0x0001.
  - tc=0, 0x80*0x02 -> 0x0100.
